mini16_s2m_collector: RTL and testbench



---
 rtl/mini16_s2m_pkg.sv | 22 ++
 rtl/mini16_rr_ptr.sv | 34 +++
 rtl/mini16_s2m_collector.sv | 152 +++++++++++++++
 tb/tb_mini16_s2m_collector.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini16_s2m_pkg.sv
// Shared types and sizing helpers for the s2m collector and its sub-modules.
package mini16_s2m_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWait  = 2'd2,
    StWrite = 2'd3
  } coll_state_e;

  // Width of one FIFO word: address field above data field.
  function automatic int unsigned fifo_w(input int unsigned width_d,
                                         input int unsigned depth_v_f);
    return width_d + depth_v_f;
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mini16_rr_ptr.sv
// Wrapping round-robin PE pointer; steps by one on i_advance, CORES-1 wraps to 0.
module mini16_rr_ptr #(
  parameter int unsigned CORES     = 4,
  parameter int unsigned CORE_BITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_advance,
  output logic [CORE_BITS-1:0] o_ptr
);

  localparam logic [CORE_BITS-1:0] LastCore = CORE_BITS'(CORES - 1);

  logic [CORE_BITS-1:0] r_ptr;
  logic [CORE_BITS-1:0] w_ptr_next;

  always_comb begin
    w_ptr_next = r_ptr;
    if (i_advance) begin
      w_ptr_next = (r_ptr == LastCore) ? '0 : r_ptr + CORE_BITS'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/mini16_s2m_collector.sv
// Round-robin drain of per-PE s2m FIFOs into the master s2m RAM write port.
// Define MINI16_S2M_COLLECTOR_STATS_EN to build the xfer_count write counter.
module mini16_s2m_collector
  import mini16_s2m_pkg::*;
#(
  parameter int unsigned WIDTH_D   = 16,
  parameter int unsigned DEPTH_V_F = 16,
  parameter int unsigned CORES     = 4,
  parameter int unsigned CORE_BITS = 2,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BURST     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   run,
  output logic [CORES-1:0]                       fifo_req_r,
  input  logic [CORES-1:0]                       fifo_valid,
  input  logic [CORES*(WIDTH_D+DEPTH_V_F)-1:0]   fifo_r_data,
  output logic                                   mem_we,
  output logic [CORE_BITS-1:0]                   mem_w_core,
  output logic [DEPTH_V_F-1:0]                   mem_w_addr,
  output logic [WIDTH_D-1:0]                     mem_w_data,
  output logic                                   busy,
  output logic [31:0]                            xfer_count
);

  localparam int unsigned FIFO_W  = fifo_w(WIDTH_D, DEPTH_V_F);
  localparam int unsigned WAIT_W  = cnt_w(RD_LAT);
  localparam int unsigned BURST_W = cnt_w(BURST - 1);

  localparam logic [WAIT_W-1:0]  WaitLast  = WAIT_W'(RD_LAT);
  localparam logic [BURST_W-1:0] BurstLast = BURST_W'(BURST - 1);

  coll_state_e r_state;
  coll_state_e w_state_next;

  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [WAIT_W-1:0]    w_wait_next;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [BURST_W-1:0]   w_burst_next;
  logic [CORE_BITS-1:0] w_ptr;
  logic                 w_advance;
  logic                 w_capture;
  logic                 w_valid;
  logic [FIFO_W-1:0]    w_slice;

  logic [CORE_BITS-1:0] r_cap_core;
  logic [DEPTH_V_F-1:0] r_cap_addr;
  logic [WIDTH_D-1:0]   r_cap_data;

  mini16_rr_ptr #(
    .CORES     (CORES),
    .CORE_BITS (CORE_BITS)
  ) u_rr_ptr (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_advance (w_advance),
    .o_ptr     (w_ptr)
  );

  // Only the polled PE's valid and slice are ever looked at.
  assign w_valid = fifo_valid[w_ptr];
  assign w_slice = fifo_r_data[w_ptr*FIFO_W +: FIFO_W];

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_burst_next = r_burst_cnt;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (run) begin
          w_state_next = StReq;
        end
      end
      StReq: begin
        w_wait_next  = '0;
        w_state_next = StWait;
      end
      StWait: begin
        if (w_valid) begin
          w_capture    = 1'b1;
          w_state_next = StWrite;
        end else if (r_wait_cnt == WaitLast) begin
          // No word within the read latency: treat this PE as empty.
          w_advance    = 1'b1;
          w_burst_next = '0;
          w_state_next = run ? StReq : StIdle;
        end else begin
          w_wait_next = r_wait_cnt + WAIT_W'(1);
        end
      end
      StWrite: begin
        if ((r_burst_cnt == BurstLast) || !run) begin
          w_advance    = 1'b1;
          w_burst_next = '0;
        end else begin
          w_burst_next = r_burst_cnt + BURST_W'(1);
        end
        w_state_next = run ? StReq : StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_cap_core  <= '0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wait_cnt  <= w_wait_next;
      r_burst_cnt <= w_burst_next;
      if (w_capture) begin
        r_cap_core <= w_ptr;
        r_cap_addr <= w_slice[FIFO_W-1 -: DEPTH_V_F];
        r_cap_data <= w_slice[WIDTH_D-1:0];
      end
    end
  end

  assign fifo_req_r = (r_state == StReq) ? (CORES'(1) << w_ptr) : '0;
  assign mem_we     = (r_state == StWrite);
  assign mem_w_core = r_cap_core;
  assign mem_w_addr = r_cap_addr;
  assign mem_w_data = r_cap_data;
  assign busy       = (r_state != StIdle);

`ifdef MINI16_S2M_COLLECTOR_STATS_EN
  logic [31:0] r_xfer_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (mem_we) begin
      r_xfer_count <= r_xfer_count + 32'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`else
  assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_mini16_s2m_collector.sv
// Scoreboard bench for mini16_s2m_collector with a behavioural model of the PE FIFOs.
module tb_mini16_s2m_collector;

  localparam int WD = 16;
  localparam int DV = 16;
  localparam int NC = 4;
  localparam int CB = 2;
  localparam int RL = 2;
  localparam int BU = 4;
  localparam int FW = WD + DV;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic [NC-1:0]     fifo_req_r;
  logic [NC-1:0]     fifo_valid;
  logic [NC*FW-1:0]  fifo_r_data;
  logic              mem_we;
  logic [CB-1:0]     mem_w_core;
  logic [DV-1:0]     mem_w_addr;
  logic [WD-1:0]     mem_w_data;
  logic              busy;
  logic [31:0]       xfer_count;

  mini16_s2m_collector #(
    .WIDTH_D   (WD),
    .DEPTH_V_F (DV),
    .CORES     (NC),
    .CORE_BITS (CB),
    .RD_LAT    (RL),
    .BURST     (BU)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .fifo_req_r  (fifo_req_r),
    .fifo_valid  (fifo_valid),
    .fifo_r_data (fifo_r_data),
    .mem_we      (mem_we),
    .mem_w_core  (mem_w_core),
    .mem_w_addr  (mem_w_addr),
    .mem_w_data  (mem_w_data),
    .busy        (busy),
    .xfer_count  (xfer_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // PE FIFO model state
  logic [FW-1:0] pe_q [NC][$];
  bit            vp [RL][NC];
  logic [FW-1:0] dp [RL][NC];
  int            last_req_pe = -1;
  bit            noise_en = 1'b0;

  // Scoreboard / monitor state
  logic [CB+FW-1:0] exp_q [$];
  int req_log [$];
  int req_cyc [$];
  int wr_cyc [$];
  int wr_cnt = 0;
  bit prev_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Model: a request seen in cycle t returns its word (if any) during cycle t+RL.
  // With noise on, PEs other than the one last requested show junk valids.
  initial begin
    logic [NC-1:0] seen;
    fifo_valid  = '0;
    fifo_r_data = '0;
    for (int s = 0; s < RL; s++) begin
      for (int i = 0; i < NC; i++) begin
        vp[s][i] = 1'b0;
        dp[s][i] = '0;
      end
    end
    forever begin
      @(negedge clk);
      seen = fifo_req_r;
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
        for (int s = RL - 1; s > 0; s--) begin
          vp[s][i] = vp[s-1][i];
          dp[s][i] = dp[s-1][i];
        end
        vp[0][i] = 1'b0;
        dp[0][i] = '0;
        if (seen[i]) begin
          last_req_pe = i;
          if (pe_q[i].size() > 0) begin
            vp[0][i] = 1'b1;
            dp[0][i] = pe_q[i].pop_front();
          end
        end
        if (reset) begin
          for (int s = 0; s < RL; s++) vp[s][i] = 1'b0;
        end
        fifo_valid[i] = vp[RL-1][i] | (noise_en && (i != last_req_pe));
        fifo_r_data[i*FW +: FW] = vp[RL-1][i] ? dp[RL-1][i] : (noise_en ? 32'hDEAD_DEAD : '0);
      end
    end
  end

  // Monitor: logs requests, checks they are one-hot single-cycle pulses, and
  // pops the scoreboard on every write.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_req_r != '0) begin
        chk("req_onehot_pulse", {62'd0, prev_req, $onehot(fifo_req_r)}, 64'd1);
        for (int i = 0; i < NC; i++) begin
          if (fifo_req_r[i]) begin
            req_log.push_back(i);
            req_cyc.push_back(cyc);
          end
        end
      end
      prev_req = |fifo_req_r;
      if (mem_we) begin
        wr_cnt++;
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          timeout("unexpected_write");
        end else begin
          chk("write_word", {mem_w_core, mem_w_addr, mem_w_data}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic load(input int pe, input logic [15:0] addr, input logic [15:0] data,
                      input bit expect_write);
    pe_q[pe].push_back({addr, data});
    if (expect_write) exp_q.push_back({CB'(pe), addr, data});
  endtask

  task automatic do_reset();
    run   = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NC; i++) pe_q[i].delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    req_log.delete();
    req_cyc.delete();
    wr_cyc.delete();
    wr_cnt = 0;
  endtask

  // pe < 0 waits for a request to any PE.
  task automatic wait_req(input int pe, input string name);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((pe < 0) ? (fifo_req_r != '0) : fifo_req_r[pe]) return;
    end
    timeout(name);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeout(name);
  endtask

  task automatic wait_writes(input int n_wr, input string name);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (wr_cnt >= n_wr) return;
    end
    timeout(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int exp_seq [11];
    exp_seq = '{0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 1};

    // Reset state
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req", 64'(fifo_req_r), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_xfer", 64'(xfer_count), 64'd0);
    chk("rst_wdata", {mem_w_core, mem_w_addr, mem_w_data}, 64'd0);

    // PE2 holds one word
    do_reset();
    load(2, 16'h0123, 16'hBEEF, 1'b1);
    run = 1'b1;
    wait_req(3, "pe2_wait_req3");
    run = 1'b0;
    wait_idle("pe2_idle");
    chk("pe2_writes", 64'(wr_cnt), 64'd1);
    n = 0;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] == 0) n++;
    chk("pe2_req0", 64'(n), 64'd1);
    n = 0;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] == 1) n++;
    chk("pe2_req1", 64'(n), 64'd1);
    n = 0;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] == 3) n++;
    chk("pe2_req3", 64'(n), 64'd1);
    k = -1;
    for (int i = req_log.size() - 1; i >= 0; i--) if (req_log[i] == 2) k = i;
    if (k >= 0 && wr_cyc.size() > 0) chk("pe2_latency", 64'(wr_cyc[0] - req_cyc[k]), 64'(RL + 1));
    else timeout("pe2_latency");

    // All FIFOs empty for 100 cycles, with junk valids on unpolled PEs
    do_reset();
    noise_en = 1'b1;
    run = 1'b1;
    repeat (100) @(negedge clk);
    run = 1'b0;
    wait_idle("empty_idle");
    noise_en = 1'b0;
    chk("empty_writes", 64'(wr_cnt), 64'd0);
    chk("empty_req_count_ge24", 64'(req_log.size() >= 24), 64'd1);
    for (int i = 0; i < req_log.size(); i++) begin
      chk("empty_req_order", 64'(req_log[i]), 64'(i % NC));
      if (i > 0) chk("empty_req_gap", 64'(req_cyc[i] - req_cyc[i-1]), 64'(RL + 2));
    end

    // PE0 holds 6 words, burst limit 4
    do_reset();
    for (int i = 0; i < 6; i++) load(0, 16'h0010 + 16'(i), 16'h1000 + 16'(i), 1'b1);
    run = 1'b1;
    wait_writes(6, "burst_writes");
    wait_req(1, "burst_req1");
    run = 1'b0;
    wait_idle("burst_idle");
    chk("burst_req_len", 64'(req_log.size()), 64'd11);
    for (int i = 0; i < 11 && i < req_log.size(); i++) chk("burst_req_seq", 64'(req_log[i]), 64'(exp_seq[i]));

    // run dropped during WAIT with a word in flight
    do_reset();
    load(0, 16'h0777, 16'h5A5A, 1'b1);
    run = 1'b1;
    wait_req(0, "drop_req0");
    @(negedge clk);
    run = 1'b0;
    wait_idle("drop_idle");
    chk("drop_writes", 64'(wr_cnt), 64'd1);
    chk("drop_busy", 64'(busy), 64'd0);
    n = req_log.size();
    repeat (20) @(negedge clk);
    chk("drop_no_more_req", 64'(req_log.size()), 64'(n));
    chk("drop_data_held", {mem_w_core, mem_w_addr, mem_w_data}, {2'd0, 16'h0777, 16'h5A5A});

    // Reset pulsed one cycle into WAIT
    do_reset();
    load(0, 16'h0BAD, 16'hF00D, 1'b0);
    run = 1'b1;
    wait_req(0, "rstw_req0");
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_we", 64'(mem_we), 64'd0);
    chk("rstw_req", 64'(fifo_req_r), 64'd0);
    chk("rstw_xfer", 64'(xfer_count), 64'd0);
    repeat (10) @(negedge clk);
    chk("rstw_no_write", 64'(wr_cnt), 64'd0);
    run = 1'b1;
    wait_req(-1, "rstw_restart");
    chk("rstw_ptr0", 64'(fifo_req_r), 64'd1);
    run = 1'b0;
    wait_idle("rstw_idle");

    // 10 words spread over the PEs
    do_reset();
    for (int i = 0; i < 3; i++) load(0, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b1);
    for (int i = 0; i < 2; i++) load(1, 16'h0200 + 16'(i), 16'hB000 + 16'(i), 1'b1);
    for (int i = 0; i < 4; i++) load(2, 16'h0300 + 16'(i), 16'hC000 + 16'(i), 1'b1);
    load(3, 16'h0400, 16'hD000, 1'b1);
    run = 1'b1;
    wait_writes(10, "stats_writes");
    run = 1'b0;
    wait_idle("stats_idle");
    chk("stats_write_count", 64'(wr_cnt), 64'd10);
`ifdef MINI16_S2M_COLLECTOR_STATS_EN
    chk("stats_xfer_count", 64'(xfer_count), 64'd10);
`else
    chk("stats_xfer_count", 64'(xfer_count), 64'd0);
`endif
    chk("stats_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
